// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests and buffers returned words for ID.
// Optional IF_PERF_CNT_EN adds saturating perf_fetched / perf_dropped / perf_stall counters.
module if_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                INSTR_W    = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                PC_STEP    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          imem_req_valid,
    output logic [ADDR_W-1:0]             imem_req_addr,
    input  logic                          imem_req_ready,
    input  logic                          imem_rsp_valid,
    input  logic [INSTR_W-1:0]            imem_rsp_data,
    input  logic                          redirect_valid,
    input  logic [ADDR_W-1:0]             redirect_pc,
    output logic                          id_valid,
    input  logic                          id_ready,
    output logic [INSTR_W-1:0]            id_instr,
    output logic [ADDR_W-1:0]             id_pc,
    output logic [ADDR_W-1:0]             id_pcplus4,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_fetched,
    output logic [31:0]                   perf_dropped,
    output logic [31:0]                   perf_stall
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic [ADDR_W-1:0]  fetch_pc_reg;
    logic [ADDR_W-1:0]  tag_mem [FIFO_DEPTH];
    logic [PW-1:0]      tag_wr_reg, tag_rd_reg;
    logic [CW-1:0]      outstanding_reg, drop_cnt_reg;
    logic [INSTR_W-1:0] instr_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]  pc_mem [FIFO_DEPTH];
    logic [PW-1:0]      fifo_wr_reg, fifo_rd_reg;
    logic [CW-1:0]      fifo_count_reg;
    logic               id_valid_reg;
    logic [INSTR_W-1:0] id_instr_reg;
    logic [ADDR_W-1:0]  id_pc_reg, id_pcplus4_reg;

    logic               req_fire, id_fire, rsp_keep, rsp_drop, head_load;
    logic [ADDR_W-1:0]  rsp_tag, head_pc, redirect_aligned;
    logic [INSTR_W-1:0] head_instr;
    logic [CW-1:0]      outstanding_next, count_after_pop;
    logic [PW-1:0]      rd_next;

    assign imem_req_valid   = rst_n && (({1'b0, fifo_count_reg} + {1'b0, outstanding_reg}) < DEPTH_C)
                              && !redirect_valid;
    assign imem_req_addr    = fetch_pc_reg;
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign id_fire          = id_valid_reg && id_ready;
    assign rsp_keep         = imem_rsp_valid && (drop_cnt_reg == '0) && !redirect_valid;
    assign rsp_drop         = imem_rsp_valid && (drop_cnt_reg != '0);
    assign rsp_tag          = tag_mem[tag_rd_reg];
    assign redirect_aligned = redirect_pc & ~(ADDR_W'(3));
    assign outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);
    assign count_after_pop  = fifo_count_reg - CW'(id_fire);
    assign rd_next          = fifo_rd_reg + PW'(id_fire);
    assign head_load        = (count_after_pop != '0) || rsp_keep;

    // An empty FIFO being written this cycle presents the incoming word directly as the next head.
    always_comb begin
        head_instr = instr_mem[rd_next];
        head_pc    = pc_mem[rd_next];
        if (count_after_pop == '0) begin
            head_instr = imem_rsp_data;
            head_pc    = rsp_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            tag_mem[tag_wr_reg] <= fetch_pc_reg;
        if (rsp_keep) begin
            instr_mem[fifo_wr_reg] <= imem_rsp_data;
            pc_mem[fifo_wr_reg]    <= rsp_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg    <= RESET_PC;
            tag_wr_reg      <= '0;
            tag_rd_reg      <= '0;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            fifo_wr_reg     <= '0;
            fifo_rd_reg     <= '0;
            fifo_count_reg  <= '0;
            id_valid_reg    <= 1'b0;
            id_instr_reg    <= '0;
            id_pc_reg       <= '0;
            id_pcplus4_reg  <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            if (req_fire)
                tag_wr_reg <= tag_wr_reg + PW'(1);
            if (imem_rsp_valid)
                tag_rd_reg <= tag_rd_reg + PW'(1);
            if (redirect_valid) begin
                // Everything still in flight after this cycle is stale, including requests already marked.
                fetch_pc_reg   <= redirect_aligned;
                drop_cnt_reg   <= outstanding_next;
                fifo_wr_reg    <= '0;
                fifo_rd_reg    <= '0;
                fifo_count_reg <= '0;
                id_valid_reg   <= 1'b0;
            end else begin
                if (req_fire)
                    fetch_pc_reg <= fetch_pc_reg + ADDR_W'(PC_STEP);
                if (rsp_drop)
                    drop_cnt_reg <= drop_cnt_reg - CW'(1);
                if (rsp_keep)
                    fifo_wr_reg <= fifo_wr_reg + PW'(1);
                fifo_rd_reg    <= rd_next;
                fifo_count_reg <= count_after_pop + CW'(rsp_keep);
                id_valid_reg   <= head_load;
                if (head_load) begin
                    id_instr_reg   <= head_instr;
                    id_pc_reg      <= head_pc;
                    id_pcplus4_reg <= head_pc + ADDR_W'(PC_STEP);
                end
            end
        end
    end

    assign id_valid   = id_valid_reg;
    assign id_instr   = id_instr_reg;
    assign id_pc      = id_pc_reg;
    assign id_pcplus4 = id_pcplus4_reg;
    assign fifo_count = fifo_count_reg;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_reg, perf_dropped_reg, perf_stall_reg;
    logic [31:0] drop_inc;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Flushed entries exclude the one ID consumes in the redirect cycle.
    always_comb begin
        drop_inc = 32'(imem_rsp_valid && !rsp_keep);
        if (redirect_valid)
            drop_inc = drop_inc + 32'(count_after_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_reg <= '0;
            perf_dropped_reg <= '0;
            perf_stall_reg   <= '0;
        end else begin
            perf_fetched_reg <= sat_add(perf_fetched_reg, 32'(id_fire));
            perf_dropped_reg <= sat_add(perf_dropped_reg, drop_inc);
            perf_stall_reg   <= sat_add(perf_stall_reg, 32'(!id_valid_reg));
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_dropped = perf_dropped_reg;
    assign perf_stall   = perf_stall_reg;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: queue-level reference model, random in-order memory, directed scenarios.
module tb_if_fetch_unit;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid, id_ready = 1'b0;
    logic [31:0] id_instr, id_pc, id_pcplus4;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    if_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC), .PC_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .id_pcplus4(id_pcplus4), .fifo_count(fifo_count)
    );

    typedef struct packed { logic [31:0] pc; logic stale; } flight_t;
    typedef struct packed { logic [31:0] addr; int due; } mreq_t;

    flight_t     flight_q[$];
    mreq_t       mem_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] hs_pc[$], hs_p4[$], req_log[$];
    logic [31:0] m_pc = RST_PC;
    logic [31:0] last_count, last_req;
    int          cyc = 0, checks = 0, errors = 0, req_count = 0;

    bit          k_redirect = 0, k_id_ready = 0, k_req_ready = 0;
    logic [31:0] k_rpc = '0;
    int          k_lat_lo = 1, k_lat_hi = 1;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // sel: 0 = handshake pc, 1 = handshake pcplus4, 2 = request address log
    task automatic check_log(input string name, input int sel, input int idx, input logic [31:0] exp);
        int sz;
        sz = (sel == 2) ? req_log.size() : hs_pc.size();
        if (sz > idx)
            check(name, (sel == 0) ? hs_pc[idx] : (sel == 1) ? hs_p4[idx] : req_log[idx], exp);
        else begin
            checks++;
            errors++;
            $display("FAIL %s entry %0d missing, only %0d logged", name, idx, sz);
        end
    endtask

    task automatic step();
        bit      exp_req, id_hs, req_hs;
        flight_t f;
        mreq_t   m;
        @(negedge clk);
        cyc++;
        redirect_valid = k_redirect;
        redirect_pc    = k_redirect ? k_rpc : $urandom();
        id_ready       = k_id_ready;
        imem_req_ready = k_req_ready;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom();
        end
        #1;
        exp_req = (fifo_q.size() + flight_q.size() < DEPTH) && !k_redirect;
        check("req_valid", 32'(imem_req_valid), 32'(exp_req));
        if (exp_req) check("req_addr", imem_req_addr, m_pc);
        check("id_valid", 32'(id_valid), 32'(fifo_q.size() != 0));
        if (fifo_q.size() != 0) begin
            check("id_pc", id_pc, fifo_q[0]);
            check("id_instr", id_instr, instr_of(fifo_q[0]));
            check("id_pcplus4", id_pcplus4, fifo_q[0] + 32'd4);
        end
        check("fifo_count", 32'(fifo_count), 32'(fifo_q.size()));
        last_count = 32'(fifo_count);
        last_req   = 32'(imem_req_valid);
        if (id_valid && id_ready) begin
            hs_pc.push_back(id_pc);
            hs_p4.push_back(id_pcplus4);
        end
        if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);

        id_hs  = (fifo_q.size() > 0) && k_id_ready;
        req_hs = exp_req && k_req_ready;
        if (id_hs) void'(fifo_q.pop_front());
        if (imem_rsp_valid) begin
            void'(mem_q.pop_front());
            if (flight_q.size() > 0) begin
                f = flight_q.pop_front();
                if (!f.stale && !k_redirect) fifo_q.push_back(f.pc);
            end
        end
        if (req_hs) begin
            f.pc = m_pc;
            f.stale = 1'b0;
            flight_q.push_back(f);
            m.addr = imem_req_addr;
            m.due  = cyc + int'($urandom_range(k_lat_hi, k_lat_lo));
            mem_q.push_back(m);
            m_pc = m_pc + 32'd4;
            req_count++;
        end
        if (k_redirect) begin
            fifo_q.delete();
            foreach (flight_q[i]) flight_q[i].stale = 1'b1;
            m_pc = {k_rpc[31:2], 2'b00};
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_instr", id_instr, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_pcplus4", id_pcplus4, 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        flight_q.delete();
        mem_q.delete();
        fifo_q.delete();
        m_pc = RST_PC;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n0;
        do_reset(3);

        // Latency 1, ID always ready: wrap through 0 and one instruction per cycle.
        k_id_ready = 1; k_req_ready = 1; k_lat_lo = 1; k_lat_hi = 1;
        repeat (12) step();
        check("steady_hs_count", 32'(hs_pc.size()), 32'd10);
        check_log("first_pc", 0, 0, 32'hFFFF_FFF8);
        check_log("first_p4", 1, 0, 32'hFFFF_FFFC);
        check_log("second_pc", 0, 1, 32'hFFFF_FFFC);
        check_log("second_p4_wrap", 1, 1, 32'h0000_0000);
        check_log("third_pc", 0, 2, 32'h0000_0000);
        check_log("fourth_pc", 0, 3, 32'h0000_0004);

        // Back-pressure after redirect to 0: exactly DEPTH requests, then drain in order.
        k_redirect = 1; k_rpc = 32'h0; step(); k_redirect = 0;
        k_id_ready = 0; req_count = 0;
        repeat (11) step();
        check("bp_req_count", 32'(req_count), 32'd4);
        check("bp_fifo_full", last_count, 32'd4);
        check("bp_req_stopped", last_req, 32'd0);
        hs_pc.delete(); hs_p4.delete(); req_log.delete();
        k_id_ready = 1;
        repeat (8) step();
        check_log("drain0", 0, 0, 32'h0);
        check_log("drain1", 0, 1, 32'h4);
        check_log("drain2", 0, 2, 32'h8);
        check_log("drain3", 0, 3, 32'hC);
        check_log("resume_addr", 2, 0, 32'h10);

        // Latency 3 with requests in flight, redirect to an unaligned target.
        k_lat_lo = 3; k_lat_hi = 3;
        n0 = 0;
        while (flight_q.size() < 2 && n0 < 20) begin step(); n0++; end
        check("lat3_inflight_reached", 32'(flight_q.size() >= 2), 32'd1);
        k_redirect = 1; k_rpc = 32'h103; step(); k_redirect = 0;
        hs_pc.delete(); hs_p4.delete();
        repeat (16) step();
        check_log("redir_pc0", 0, 0, 32'h100);
        check_log("redir_pc1", 0, 1, 32'h104);

        // Redirect coinciding with an ID handshake and a memory response.
        k_lat_lo = 1; k_lat_hi = 1;
        repeat (6) step();
        n0 = hs_pc.size();
        k_redirect = 1; k_rpc = 32'h200; step(); k_redirect = 0;
        check("redir_hs_honoured", 32'(hs_pc.size() - n0), 32'd1);
        hs_pc.delete(); hs_p4.delete();
        repeat (6) step();
        check_log("redir_target", 0, 0, 32'h200);

        // Reset mid-stream with a full FIFO; fetch restarts at RESET_PC.
        k_id_ready = 0;
        repeat (10) step();
        check("full_before_reset", last_count, 32'd4);
        do_reset(2);
        k_id_ready = 1;
        hs_pc.delete(); hs_p4.delete(); req_log.delete();
        repeat (6) step();
        check_log("restart_req", 2, 0, RST_PC);
        check_log("restart_pc", 0, 0, RST_PC);

        // Randomised traffic.
        k_lat_lo = 1; k_lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            k_id_ready  = ($urandom_range(0, 9) < 7);
            k_req_ready = ($urandom_range(0, 3) != 0);
            k_redirect  = ($urandom_range(0, 29) == 0);
            k_rpc       = $urandom();
            if ($urandom_range(0, 999) == 0) do_reset(1 + int'($urandom_range(0, 2)));
            step();
        end
        k_redirect = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
